ltc2308_adc_emulator: RTL

Synthesizable slave-side model of the 4-wire LTC2308 serial ADC interface. The `adc_CONVST`/`adc_SCK`/`adc_SDI` outputs of the FPGA ADC controller drive it, and it returns `adc_SDO`. It serves loopback bring-up and hardware-in-the-loop tests of the HPS ADC path without the physical converter. Sample values come from a fabric-side request/valid port, so a test-pattern generator or a DMA source can feed it.

---
 rtl/ltc2308_pkg.sv | 32 +++
 rtl/pin_sync_edge.sv | 46 ++++
 rtl/ltc2308_adc_emulator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg
// Shared types and constants for the LTC2308 serial ADC emulator.
//   state_e      : readout FSM states
//   CFG_*        : bit positions inside the 6-bit config word {S/D, O/S, S1, S0, UNI, SLP}
//   RESULT_BITS  : width of a conversion result
//   CFG_BITS     : width of the config word
//   cfg_to_ch()  : maps a config word to the 3-bit channel index {S1, S0, O/S}

package ltc2308_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StWait,
        StShift
    } state_e;

    localparam int unsigned CFG_SD  = 5;
    localparam int unsigned CFG_OS  = 4;
    localparam int unsigned CFG_S1  = 3;
    localparam int unsigned CFG_S0  = 2;
    localparam int unsigned CFG_UNI = 1;
    localparam int unsigned CFG_SLP = 0;

    localparam int unsigned RESULT_BITS = 12;
    localparam int unsigned CFG_BITS    = 6;

    function automatic logic [2:0] cfg_to_ch(input logic [CFG_BITS-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// pin_sync_edge
// Multi-flop synchronizer for one asynchronous pin with registered edge strobes.
//   clk    : sampling clock
//   reset  : synchronous active-high reset, clears every flop to 0
//   pin    : asynchronous input pin
//   level  : synchronized pin level, time-aligned with the strobes
//   rise   : one-cycle strobe on a 0->1 transition (STAGES+1 cycles after the pin)
//   fall   : one-cycle strobe on a 1->0 transition (STAGES+1 cycles after the pin)

module pin_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    // prev_q holds the level that produced the current strobes, so the level and
    // strobes seen by the consumer always agree.
    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ltc2308_adc_emulator.sv
// ltc2308_adc_emulator
// Slave-side model of the LTC2308 4-wire serial ADC interface. Samples are requested
// from the fabric during each conversion and shifted out MSB first on SDO.
//   clk_clk     : single clock, rising edge
//   reset_reset : synchronous active-high reset
//   adc_CONVST  : conversion start pin (asynchronous)
//   adc_SCK     : serial clock pin (asynchronous)
//   adc_SDI     : config data pin, sampled on SCK rise
//   adc_SDO     : result data pin, MSB first, changes after SCK fall
//   smp_req     : level request for a sample during conversion
//   smp_ch      : channel index {S1, S0, O/S} of the active config
//   smp_cfg     : active config word
//   smp_valid   : smp_data valid, taken only while smp_req is high
//   smp_data    : sample value
//   cfg_update  : one-cycle pulse when a new config word becomes active
//   busy        : high while converting
//   smp_miss    : one-cycle pulse when a conversion ends without a sample
//   proto_err   : one-cycle pulse for an SCK edge during conversion

module ltc2308_adc_emulator
    import ltc2308_pkg::*;
#(
    parameter int unsigned         CONV_CYCLES = 80,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 6'b100010
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   adc_CONVST,
    input  logic                   adc_SCK,
    input  logic                   adc_SDI,
    output logic                   adc_SDO,
    output logic                   smp_req,
    output logic [2:0]             smp_ch,
    output logic [CFG_BITS-1:0]    smp_cfg,
    input  logic                   smp_valid,
    input  logic [RESULT_BITS-1:0] smp_data,
    output logic                   cfg_update,
    output logic                   busy,
    output logic                   smp_miss,
    output logic                   proto_err
);

    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [2:0] RISE_MAX = 3'(CFG_BITS);
    localparam logic [3:0] FALL_MAX = 4'(RESULT_BITS);

    // Synchronized pin views
    logic convst_level, convst_rise, convst_fall;
    logic sck_level, sck_rise, sck_fall;
    logic sdi_level, sdi_rise, sdi_fall;

    pin_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_convst (
        .clk   (clk_clk),
        .reset (reset_reset),
        .pin   (adc_CONVST),
        .level (convst_level),
        .rise  (convst_rise),
        .fall  (convst_fall)
    );

    pin_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sck (
        .clk   (clk_clk),
        .reset (reset_reset),
        .pin   (adc_SCK),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    pin_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sdi (
        .clk   (clk_clk),
        .reset (reset_reset),
        .pin   (adc_SDI),
        .level (sdi_level),
        .rise  (sdi_rise),
        .fall  (sdi_fall)
    );

    // SDI is consumed as a level only; SCK level is implied by its strobes.
    logic unused_sync;
    assign unused_sync = ^{sck_level, sdi_rise, sdi_fall};

    // State
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [RESULT_BITS-1:0] result_q;
    logic [RESULT_BITS-1:0] out_sr_q;
    logic [CFG_BITS-1:0]    cfg_q;
    logic [CFG_BITS-1:0]    cfg_sr_q;
    logic [2:0]             rise_cnt_q;
    logic [3:0]             fall_cnt_q;
    logic                   sdo_q;
    logic                   req_q;
    logic                   busy_q;
    logic                   cfg_update_q;
    logic                   smp_miss_q;
    logic                   proto_err_q;

    // Next-state helpers
    logic                   start_conv;
    logic                   take_smp;
    logic                   conv_last;
    logic                   miss_now;
    logic [RESULT_BITS-1:0] res_next;

    always_comb begin
        start_conv = convst_rise && ((state_q == StIdle) || (state_q == StShift));
        conv_last  = (state_q == StConv) && (cnt_q == CNT_LAST);
        take_smp   = (state_q == StConv) && req_q && smp_valid;
        // A sample arriving on the final count still wins over the miss.
        miss_now   = conv_last && req_q && !smp_valid;
        res_next   = result_q;
        if (take_smp) begin
            res_next = smp_data;
        end else if (miss_now) begin
            res_next = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            result_q     <= '0;
            out_sr_q     <= '0;
            cfg_q        <= DEFAULT_CFG;
            cfg_sr_q     <= '0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            sdo_q        <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            cfg_update_q <= 1'b0;
            smp_miss_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            smp_miss_q   <= 1'b0;
            proto_err_q  <= 1'b0;

            if (start_conv) begin
                // CONVST rise has priority over any SCK edge in the same cycle.
                state_q    <= StConv;
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                req_q      <= 1'b1;
                sdo_q      <= 1'b0;
                rise_cnt_q <= '0;
                if (rise_cnt_q == RISE_MAX) begin
                    cfg_q        <= cfg_sr_q;
                    cfg_update_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        sdo_q <= 1'b0;
                    end

                    StConv: begin
                        proto_err_q <= sck_rise | sck_fall;
                        result_q    <= res_next;
                        if (take_smp || miss_now) begin
                            req_q <= 1'b0;
                        end
                        smp_miss_q <= miss_now;
                        if (conv_last) begin
                            busy_q <= 1'b0;
                            if (convst_level) begin
                                state_q <= StWait;
                            end else begin
                                state_q    <= StShift;
                                out_sr_q   <= res_next;
                                sdo_q      <= res_next[RESULT_BITS-1];
                                rise_cnt_q <= '0;
                                fall_cnt_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    StWait: begin
                        if (convst_fall) begin
                            state_q    <= StShift;
                            out_sr_q   <= result_q;
                            sdo_q      <= result_q[RESULT_BITS-1];
                            rise_cnt_q <= '0;
                            fall_cnt_q <= '0;
                        end
                    end

                    StShift: begin
                        if (sck_rise && (rise_cnt_q < RISE_MAX)) begin
                            cfg_sr_q   <= {cfg_sr_q[CFG_BITS-2:0], sdi_level};
                            rise_cnt_q <= rise_cnt_q + 3'd1;
                        end
                        // Zeros shift in behind the result, so the 12th fall leaves SDO low.
                        if (sck_fall && (fall_cnt_q < FALL_MAX)) begin
                            out_sr_q   <= {out_sr_q[RESULT_BITS-2:0], 1'b0};
                            sdo_q      <= out_sr_q[RESULT_BITS-2];
                            fall_cnt_q <= fall_cnt_q + 4'd1;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign adc_SDO    = sdo_q;
    assign smp_req    = req_q;
    assign smp_cfg    = cfg_q;
    assign smp_ch     = cfg_to_ch(cfg_q);
    assign cfg_update = cfg_update_q;
    assign busy       = busy_q;
    assign smp_miss   = smp_miss_q;
    assign proto_err  = proto_err_q;

endmodule
